// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// in_ready is a pure function of state, so decode back-pressure never reaches fetch combinationally.
module if_id_skid_stage #(
    parameter int                 PC_W      = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic [1:0]         occupancy
);

    // State encoding equals the number of held entries.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;

    logic in_xfer;
    logic out_xfer;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign occupancy = state_q;
    assign out_pc    = out_valid ? main_pc_q    : '0;
    assign out_instr = out_valid ? main_instr_q : NOP_INSTR;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ONE;
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_pc_d    = in_pc;
                        main_instr_d = in_instr;
                    end else if (in_xfer) begin
                        state_d      = FULL;
                        skid_pc_d    = in_pc;
                        skid_instr_d = in_instr;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry is always the younger one, so it moves up to main.
                    if (out_xfer) begin
                        state_d      = ONE;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: payload registers are deliberately not reset; the output mask hides them while invalid.
    always_ff @(posedge clk) begin
        main_pc_q    <= main_pc_d;
        main_instr_q <= main_instr_d;
        skid_pc_q    <= skid_pc_d;
        skid_instr_q <= skid_instr_d;
    end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: a FIFO-queue model checked every cycle plus literal pins.
module tb_if_id_skid_stage;

    localparam int                PC_W    = 64;
    localparam int                INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP    = 32'h00000013;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic [1:0]         occupancy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t model_q[$];

    if_id_skid_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage is a 2-deep FIFO; flush and reset empty it, pops happen before pushes.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            automatic bit do_in  = in_valid && (model_q.size() < 2);
            automatic bit do_out = (model_q.size() > 0) && out_ready;
            if (do_out) void'(model_q.pop_front());
            if (do_in)  model_q.push_back('{pc: in_pc, instr: in_instr});
        end
    end

    always @(negedge clk) begin
        automatic int n = model_q.size();
        check("m_occupancy", 64'(occupancy), 64'(n));
        check("m_out_valid", 64'(out_valid), 64'(n > 0));
        check("m_in_ready",  64'(in_ready),  64'(n < 2));
        check("m_out_pc",    64'(out_pc),    (n > 0) ? 64'(model_q[0].pc)    : 64'd0);
        check("m_out_instr", 64'(out_instr), (n > 0) ? 64'(model_q[0].instr) : 64'(NOP));
    end

    task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b1, 64'h55, 32'hdeadbeef, 1'b1, 1'b0);
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_instr", 64'(out_instr), 64'h13);
        check("rst_out_pc",    out_pc,         64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        in_valid = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();

        // Streaming: each input appears one cycle later.
        drive(1'b1, 64'h0, 32'hA000_0001, 1'b1, 1'b0); cycle();
        check("str_pc0",  out_pc, 64'h0);
        check("str_ins0", 64'(out_instr), 64'hA000_0001);
        check("str_occ0", 64'(occupancy), 64'd1);
        drive(1'b1, 64'h4, 32'hB000_0002, 1'b1, 1'b0); cycle();
        check("str_pc1",  out_pc, 64'h4);
        check("str_occ1", 64'(occupancy), 64'd1);
        drive(1'b1, 64'h8, 32'hC000_0003, 1'b1, 1'b0); cycle();
        check("str_pc2",  out_pc, 64'h8);
        check("str_ins2", 64'(out_instr), 64'hC000_0003);
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0); cycle();
        check("str_drain", 64'(occupancy), 64'd0);

        // Back-pressure into FULL, then drain in order.
        drive(1'b1, 64'h100, 32'hAAAA_0100, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h104, 32'hBBBB_0104, 1'b0, 1'b0); cycle();
        check("bp_occ",      64'(occupancy), 64'd2);
        check("bp_in_ready", 64'(in_ready),  64'd0);
        check("bp_hold_pc",  out_pc,         64'h100);
        drive(1'b1, 64'h108, 32'hCCCC_0108, 1'b0, 1'b0); cycle();
        check("bp_stable",   64'(out_instr), 64'hAAAA_0100);
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0); cycle();
        check("bp_second",   out_pc,         64'h104);
        check("bp_occ1",     64'(occupancy), 64'd1);
        cycle();
        check("bp_empty",    64'(occupancy), 64'd0);

        // Simultaneous in and out transfer while ONE.
        drive(1'b1, 64'h200, 32'hD000_0200, 1'b1, 1'b0); cycle();
        drive(1'b1, 64'h204, 32'hE000_0204, 1'b1, 1'b0); cycle();
        check("sim_occ", 64'(occupancy), 64'd1);
        check("sim_pc",  out_pc,         64'h204);
        check("sim_ins", 64'(out_instr), 64'hE000_0204);

        // Flush while FULL with a valid input presented.
        drive(1'b1, 64'h300, 32'hF000_0300, 1'b0, 1'b0); cycle();
        check("fl_full", 64'(occupancy), 64'd2);
        drive(1'b1, 64'h400, 32'h1234_0400, 1'b1, 1'b1); cycle();
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        check("fl_occ",   64'(occupancy), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_nop",   64'(out_instr), 64'h13);
        check("fl_ready", 64'(in_ready),  64'd1);
        cycle();
        check("fl_nocap", 64'(occupancy), 64'd0);

        // Asynchronous reset between edges while FULL.
        drive(1'b1, 64'h500, 32'h5555_0500, 1'b0, 1'b0); cycle();
        drive(1'b1, 64'h504, 32'h6666_0504, 1'b0, 1'b0); cycle();
        check("ar_full", 64'(occupancy), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_occ",   64'(occupancy), 64'd0);
        check("ar_ready", 64'(in_ready),  64'd1);
        check("ar_pc",    out_pc,         64'd0);
        check("ar_nop",   64'(out_instr), 64'h13);
        in_valid = 1'b0;
        cycle();
        reset_n = 1'b1;
        cycle();
        drive(1'b1, 64'h600, 32'h7777_0600, 1'b1, 1'b0); cycle();
        check("ar_resume", out_pc, 64'h600);

        // Mixed handshake pattern exercised against the model only.
        for (int i = 0; i < 24; i++) begin
            drive((i % 3) != 2, 64'h1000 + 64'(4 * i), 32'h9000_0000 + 32'(i),
                  (i % 4) != 0, i == 13);
            cycle();
        end
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        cycle();
        cycle();
        check("end_empty", 64'(occupancy), 64'd0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
